pc_fetch_sequencer: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch over a ready/valid instruction-memory port.
- Presents one instruction at a time to decode.
- When decode consumes the instruction, selects the next PC from trap entry, trap return, the next-PC unit's redirect target, or PC+4.
- Sits between the next-PC unit and instruction memory, and replaces the bare PC register.

---
 rtl/pc_fetch_sequencer_if.sv | 22 ++
 rtl/pc_fetch_sequencer.sv | 101 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// The memory accepts a request and returns the word in the same cycle that ready is high.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: fetches one instruction at a time over imem and holds it for decode,
// then picks the next PC from trap entry, trap return, redirect or PC+4.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  pc_fetch_sequencer_if.master         imem,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall,
  input  logic                         trap_req,
  input  logic                         mret_req,
  output logic [31:0]                  pc_out,
  output logic [31:0]                  inst,
  output logic                         inst_valid,
  output logic [31:0]                  epc_out,
  output logic                         misalign_err,
  output logic [31:0]                  instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, epc, epc_nxt, sel_pc;
  logic        consume, take_trap, misalign_nxt, retire, capture;

  assign imem.imem_req  = (state == REQ) || (state == WAIT);
  assign imem.imem_addr = pc;
  assign capture        = imem.imem_req && imem.imem_ready;
  assign pc_out         = pc;
  assign epc_out        = epc;
  assign inst_valid     = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next state and next PC; the PC only moves when decode consumes the held instruction.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    epc_nxt      = epc;
    sel_pc       = pc + 32'd4;
    consume      = 1'b0;
    take_trap    = 1'b0;
    misalign_nxt = 1'b0;
    retire       = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ, WAIT: state_nxt = imem.imem_ready ? HOLD : WAIT;
      HOLD: begin
        consume = !stall || trap_req;
        if (consume) begin
          state_nxt = REQ;
          if (trap_req) begin
            take_trap = 1'b1;
          end else begin
            if (mret_req)            sel_pc = epc;
            else if (redirect_valid) sel_pc = redirect_pc;
            // A misaligned target becomes a trap and the instruction does not retire.
            if (ALIGN_CHECK && (sel_pc[1:0] != 2'b00)) begin
              take_trap    = 1'b1;
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt = sel_pc;
              retire = 1'b1;
            end
          end
          if (take_trap) begin
            epc_nxt = pc;
            pc_nxt  = TRAP_VEC;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      epc          <= 32'h0;
      inst         <= NOP;
      instret      <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      epc          <= epc_nxt;
      misalign_err <= misalign_nxt;
      if (capture) inst    <= imem.imem_rdata;
      if (retire)  instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer: acts as memory and datapath, and predicts
// PC/EPC/instret per instruction from the architectural next-PC rules.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid, stall, trap_req, mret_req;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, inst, epc_out, instret;
  logic        inst_valid, misalign_err;

  pc_fetch_sequencer_if imem();

  pc_fetch_sequencer #(
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem(imem),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .trap_req(trap_req),
    .mret_req(mret_req),
    .pc_out(pc_out),
    .inst(inst),
    .inst_valid(inst_valid),
    .epc_out(epc_out),
    .misalign_err(misalign_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc, m_epc, m_instret;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full instruction: fetch with some wait cycles, hold with some stalls, then consume.
  task automatic applyStimulus(input int waits, input int stalls, input bit trap, input bit trap_stall,
                               input bit mret, input bit redir, input logic [31:0] rpc,
                               input logic [31:0] rdata);
    logic [31:0] sel;
    logic        mis_exp;
    checkOutput("req_start", {31'b0, imem.imem_req}, 32'd1);
    checkOutput("addr_start", imem.imem_addr, m_pc);
    checkOutput("valid_start", {31'b0, inst_valid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = $urandom;
      trap_req        = 1'($urandom);
      mret_req        = 1'($urandom);
      redirect_valid  = 1'($urandom);
      redirect_pc     = $urandom;
      stall           = 1'($urandom);
      @(negedge clk);
      checkOutput("wait_req", {31'b0, imem.imem_req}, 32'd1);
      checkOutput("wait_addr", imem.imem_addr, m_pc);
      checkOutput("wait_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("wait_misalign", {31'b0, misalign_err}, 32'd0);
    end
    imem.imem_ready = 1'b1;
    imem.imem_rdata = rdata;
    @(negedge clk);
    imem.imem_ready = 1'($urandom);
    imem.imem_rdata = $urandom;
    checkOutput("cap_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("cap_inst", inst, rdata);
    checkOutput("cap_req", {31'b0, imem.imem_req}, 32'd0);
    checkOutput("cap_pc", pc_out, m_pc);
    checkOutput("cap_misalign", {31'b0, misalign_err}, 32'd0);
    for (int s = 0; s < stalls; s++) begin
      stall          = 1'b1;
      trap_req       = 1'b0;
      mret_req       = mret;
      redirect_valid = redir;
      redirect_pc    = rpc;
      @(negedge clk);
      checkOutput("stall_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("stall_inst", inst, rdata);
      checkOutput("stall_pc", pc_out, m_pc);
      checkOutput("stall_instret", instret, m_instret);
    end
    trap_req       = trap;
    stall          = trap ? trap_stall : 1'b0;
    mret_req       = mret;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mis_exp        = 1'b0;
    if (trap) begin
      m_epc = m_pc;
      m_pc  = TRAP_VEC;
    end else begin
      sel = mret ? m_epc : (redir ? rpc : m_pc + 32'd4);
      if (sel % 4 != 0) begin
        mis_exp = 1'b1;
        m_epc   = m_pc;
        m_pc    = TRAP_VEC;
      end else begin
        m_pc      = sel;
        m_instret = m_instret + 32'd1;
      end
    end
    @(negedge clk);
    trap_req       = 1'b0;
    mret_req       = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    checkOutput("next_pc", pc_out, m_pc);
    checkOutput("next_epc", epc_out, m_epc);
    checkOutput("next_instret", instret, m_instret);
    checkOutput("next_misalign", {31'b0, misalign_err}, {31'b0, mis_exp});
    checkOutput("next_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    stall           = 1'b0;
    trap_req        = 1'b0;
    mret_req        = 1'b0;
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h0050_0093;
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", pc_out, RESET_PC);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_req", {31'b0, imem.imem_req}, 32'd0);
    checkOutput("rst_epc", epc_out, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("boot_req", {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk);
    m_pc      = RESET_PC;
    m_epc     = 32'h0;
    m_instret = 32'h0;

    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0050_0093);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h1111_1111);
    applyStimulus(3, 0, 0, 0, 0, 0, 32'h0, 32'h2222_2222);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h3333_3333);
    applyStimulus(0, 2, 0, 0, 0, 1, 32'h0000_0040, 32'h4444_4444);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0020, 32'h5555_5555);
    applyStimulus(0, 1, 1, 1, 0, 0, 32'h0, 32'h6666_6666);
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, 32'h7777_7777);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0030, 32'h8888_8888);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0042, 32'h9999_9999);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hAAAA_AAAA);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'hBBBB_BBBB);
    applyStimulus(0, 0, 1, 0, 1, 0, 32'h0, 32'hCCCC_CCCC);

    for (int i = 0; i < 300; i++) begin
      r      = $urandom;
      r[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 7) == 0, 1'($urandom),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                    r, $urandom);
    end

    // Asynchronous reset in the middle of a fetch takes effect without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_pc", pc_out, RESET_PC);
    checkOutput("arst_req", {31'b0, imem.imem_req}, 32'd0);
    checkOutput("arst_instret", instret, 32'd0);
    checkOutput("arst_epc", epc_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
